// File: rtl/gate_tester4.sv
// Stimulus-and-check harness for a 4-input combinational gate: walks all 16 input
// vectors, samples y_dut after SETTLE_CYCLES and scores it against TRUTH_TABLE.
// Optional build macro GT_CAPTURE_EN adds the observed[15:0] capture port.
module gate_tester4 #(
    parameter logic [15:0] TRUTH_TABLE   = 16'h7FFF,
    parameter int          SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       y_dut,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] fail_count,
    output logic [3:0] first_fail,
    output logic       first_fail_valid
`ifdef GT_CAPTURE_EN
    ,
    output logic [15:0] observed
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] fail_count_q, fail_count_d;
    logic [3:0] first_fail_q, first_fail_d;
    logic       ffv_q, ffv_d;
    logic       sample_hit;
    logic       mismatch;
`ifdef GT_CAPTURE_EN
    logic [15:0] observed_q, observed_d;
`endif

    assign sample_hit = (state_q == ST_RUN) && (cnt_q == SETTLE_LAST);
    assign mismatch   = (y_dut != TRUTH_TABLE[vec_q]);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        cnt_d        = cnt_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        ffv_d        = ffv_q;
`ifdef GT_CAPTURE_EN
        observed_d   = observed_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_RUN;
                    vec_d        = 4'd0;
                    cnt_d        = 4'd0;
                    fail_count_d = 5'd0;
                    first_fail_d = 4'd0;
                    ffv_d        = 1'b0;
`ifdef GT_CAPTURE_EN
                    observed_d   = 16'h0000;
`endif
                end
            end
            ST_RUN: begin
                if (sample_hit) begin
                    if (mismatch) begin
                        fail_count_d = fail_count_q + 5'd1;
                        if (!ffv_q) begin
                            first_fail_d = vec_q;
                            ffv_d        = 1'b1;
                        end
                    end
`ifdef GT_CAPTURE_EN
                    observed_d[vec_q] = y_dut;
`endif
                    // The sampling edge also applies the next vector: no idle gap.
                    if (vec_q == 4'd15) begin
                        state_d = ST_DONE;
                    end else begin
                        vec_d = vec_q + 4'd1;
                        cnt_d = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= 4'd0;
            cnt_q        <= 4'd0;
            fail_count_q <= 5'd0;
            first_fail_q <= 4'd0;
            ffv_q        <= 1'b0;
`ifdef GT_CAPTURE_EN
            observed_q   <= 16'h0000;
`endif
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            cnt_q        <= cnt_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            ffv_q        <= ffv_d;
`ifdef GT_CAPTURE_EN
            observed_q   <= observed_d;
`endif
        end
    end

    // Stimulus is forced to zero outside RUN so the gate idles at vector 0.
    assign {a, b, c, d}     = (state_q == ST_RUN) ? vec_q : 4'd0;
    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_DONE);
    assign pass             = (state_q == ST_DONE) && (fail_count_q == 5'd0);
    assign fail_count       = fail_count_q;
    assign first_fail       = first_fail_q;
    assign first_fail_valid = ffv_q;
`ifdef GT_CAPTURE_EN
    assign observed         = observed_q;
`endif

endmodule

// File: tb/tb_gate_tester4.sv
// Self-checking bench for gate_tester4: two instances (default NAND4 table with S=2,
// AND4 table with S=3) driven by table-defined gate models, scored by a popcount model.
module tb_gate_tester4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start1 = 1'b0;
    logic        start2 = 1'b0;
    logic [15:0] fn1 = 16'h7FFF;
    logic [15:0] fn2 = 16'h7FFF;
    int          sel = 0;
    int          checks = 0;
    int          errors = 0;

    logic       a1, b1, c1, d1, busy1, done1, pass1, ffv1;
    logic       a2, b2, c2, d2, busy2, done2, pass2, ffv2;
    logic [4:0] fc1, fc2;
    logic [3:0] ff1, ff2;
    logic       y1, y2;
`ifdef GT_CAPTURE_EN
    logic [15:0] obs1, obs2;
`endif

    // The gate under test is a lookup table indexed by {a,b,c,d}.
    assign y1 = fn1[{a1, b1, c1, d1}];
    assign y2 = fn2[{a2, b2, c2, d2}];

    gate_tester4 dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .y_dut(y1),
        .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fc1), .first_fail(ff1), .first_fail_valid(ffv1)
`ifdef GT_CAPTURE_EN
        , .observed(obs1)
`endif
    );

    gate_tester4 #(.TRUTH_TABLE(16'h8000), .SETTLE_CYCLES(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .a(a2), .b(b2), .c(c2), .d(d2), .y_dut(y2),
        .busy(busy2), .done(done2), .pass(pass2),
        .fail_count(fc2), .first_fail(ff2), .first_fail_valid(ffv2)
`ifdef GT_CAPTURE_EN
        , .observed(obs2)
`endif
    );

    always #5 clk = ~clk;

    logic [3:0] vec_o;
    logic       busy_o, done_o, pass_o, ffv_o;
    logic [4:0] fc_o;
    logic [3:0] ff_o;
    assign vec_o  = (sel != 0) ? {a2, b2, c2, d2} : {a1, b1, c1, d1};
    assign busy_o = (sel != 0) ? busy2 : busy1;
    assign done_o = (sel != 0) ? done2 : done1;
    assign pass_o = (sel != 0) ? pass2 : pass1;
    assign ffv_o  = (sel != 0) ? ffv2 : ffv1;
    assign fc_o   = (sel != 0) ? fc2 : fc1;
    assign ff_o   = (sel != 0) ? ff2 : ff1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int popcount16(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int lowest_set(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic set_start(input int s, input logic v);
        if (s != 0) start2 = v;
        else        start1 = v;
    endtask

    // One full run; expected results come from the XOR of gate table and truth table.
    task automatic run_chk(input int s, input logic [15:0] fn, input bit mid_start, input string tag);
        int          sc;
        logic [15:0] tt, miss;
        sel  = s;
        sc   = (s != 0) ? 3 : 2;
        tt   = (s != 0) ? 16'h8000 : 16'h7FFF;
        miss = fn ^ tt;
        if (s != 0) fn2 = fn;
        else        fn1 = fn;
        set_start(s, 1'b1);
        tick();
        set_start(s, 1'b0);
        chk({tag, ".accept_state"}, {busy_o, done_o, pass_o, ffv_o}, 4'b1000);
        chk({tag, ".accept_cleared"}, {fc_o, ff_o}, 9'd0);
        chk({tag, ".vec0"}, vec_o, 4'd0);
        for (int n = 1; n <= 16 * sc; n++) begin
            if (mid_start && n == 10) set_start(s, 1'b1);
            tick();
            set_start(s, 1'b0);
            if (n < 16 * sc)
                chk($sformatf("%s.step%0d", tag, n), {busy_o, done_o, vec_o}, {1'b1, 1'b0, 4'(n / sc)});
        end
        chk({tag, ".done_flags"}, {busy_o, done_o, vec_o}, {1'b0, 1'b1, 4'd0});
        chk({tag, ".fail_count"}, fc_o, popcount16(miss));
        chk({tag, ".first_fail"}, ff_o, lowest_set(miss));
        chk({tag, ".ffv"}, ffv_o, (miss != 16'h0));
        chk({tag, ".pass"}, pass_o, (miss == 16'h0));
`ifdef GT_CAPTURE_EN
        chk({tag, ".observed"}, (s != 0) ? obs2 : obs1, fn);
`endif
        tick();
        tick();
        chk({tag, ".hold"}, {busy_o, done_o, fc_o, ff_o}, {1'b0, 1'b1, 5'(popcount16(miss)), 4'(lowest_set(miss))});
        $display("run %s: fn=%04h fail_count=%0d first_fail=%0d pass=%0b", tag, fn, fc_o, ff_o, pass_o);
    endtask

    initial begin
        #12;
        sel = 0;
        chk("reset.dut1", {a1, b1, c1, d1, busy1, done1, pass1, fc1, ff1, ffv1}, 18'd0);
        chk("reset.dut2", {a2, b2, c2, d2, busy2, done2, pass2, fc2, ff2, ffv2}, 18'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("idle_after_reset", {busy1, done1}, 2'b00);

        run_chk(0, 16'h7FFF, 1'b0, "nand4");
        run_chk(0, 16'hFFFF, 1'b0, "stuck1");
        run_chk(0, 16'h0000, 1'b0, "stuck0");
        run_chk(0, 16'h7FFF, 1'b0, "restart_clears");
        run_chk(0, 16'h7FFF, 1'b1, "mid_start");
        run_chk(1, 16'h7FFF, 1'b0, "and4_s3");
        for (int r = 0; r < 4; r++) begin
            run_chk(r % 2, 16'($urandom), 1'b0, $sformatf("rand%0d", r));
        end

        // Abandon a run while vector 5 is applied, with failures already counted.
        sel = 0;
        fn1 = 16'h0000;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int n = 1; n <= 10; n++) tick();
        chk("pre_reset.vec", {a1, b1, c1, d1}, 4'd5);
        chk("pre_reset.fail_count", fc1, 5'd5);
        #2 rst = 1'b1;
        #1;
        chk("async_reset", {a1, b1, c1, d1, busy1, done1, pass1, fc1, ff1, ffv1}, 18'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_reset_idle", {busy1, done1, a1, b1, c1, d1}, 6'd0);
        run_chk(0, 16'h7FFF, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
